// File: rtl/sumador_serial_if.sv
// Operand/result bundle for the bit-serial adder: start/busy/done handshake
// plus the operand and result buses.
interface sumador_serial_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] num1;
  logic [N-1:0] num2;
  logic         busy;
  logic         done;
  logic [N-1:0] Result;
  logic         Carryout;

  modport master (
    output start, num1, num2,
    input  busy, done, Result, Carryout
  );

  modport slave (
    input  start, num1, num2,
    output busy, done, Result, Carryout
  );
endinterface

// File: rtl/sumador_serial.sv
// Bit-serial N-bit adder: one full-adder step per clock, LSB first.
// Result/Carryout update only on entry to DONE, so partial sums never leak out.
module sumador_serial #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sumador_serial_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  a_reg, a_next;
  logic [N-1:0]  b_reg, b_next;
  logic [N-1:0]  s_reg, s_next;
  logic [N-1:0]  result_reg, result_next;
  logic          c_reg, c_next;
  logic          carry_reg, carry_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          sum_bit;
  logic          carry_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      s_reg      <= '0;
      result_reg <= '0;
      c_reg      <= 1'b0;
      carry_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      s_reg      <= s_next;
      result_reg <= result_next;
      c_reg      <= c_next;
      carry_reg  <= carry_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    s_next      = s_reg;
    result_next = result_reg;
    c_next      = c_reg;
    carry_next  = carry_reg;
    cnt_next    = cnt_reg;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    sum_bit     = a_reg[0] ^ b_reg[0] ^ c_reg;
    carry_bit   = (a_reg[0] & b_reg[0]) | (c_reg & (a_reg[0] ^ b_reg[0]));

    // busy/done are computed from the next state so they are plain flops
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_next     = bus.num1;
          b_next     = bus.num2;
          c_next     = 1'b0;
          cnt_next   = '0;
          state_next = SHIFT;
          busy_next  = 1'b1;
        end
      end
      SHIFT: begin
        c_next = carry_bit;
        a_next = a_reg >> 1;
        b_next = b_reg >> 1;
        s_next = {sum_bit, s_reg[N-1:1]};
        if (cnt_reg == CW'(N - 1)) begin
          // last bit: publish the completed sum; counter parks at N-1
          result_next = {sum_bit, s_reg[N-1:1]};
          carry_next  = carry_bit;
          state_next  = DONE;
          done_next   = 1'b1;
        end else begin
          cnt_next  = cnt_reg + CW'(1);
          busy_next = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.Result   = result_reg;
  assign bus.Carryout = carry_reg;
endmodule

// File: tb/tb_sumador_serial.sv
// Directed + random bench for sumador_serial at N=4 and N=8 against a
// cycle-phase model of the start/busy/done protocol and plain-integer sums.
module tb_sumador_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sumador_serial_if #(.N(4)) bus4 ();
  sumador_serial_if #(.N(8)) bus8 ();

  sumador_serial #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  sumador_serial #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  int checks = 0;
  int fails  = 0;

  // model: phase 0 idle, 1..n adding, n+1 done pulse
  int         ph[2]      = '{0, 0};
  logic [8:0] pend[2]    = '{9'd0, 9'd0};
  logic [7:0] exp_res[2] = '{8'd0, 8'd0};
  logic       exp_co[2]  = '{1'b0, 1'b0};
  int         done_cnt[2] = '{0, 0};
  int         busy_cnt[2] = '{0, 0};

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int i, input int n, input logic st, input logic [8:0] sum);
    if (ph[i] == 0) begin
      if (st) begin
        ph[i]   = 1;
        pend[i] = sum;
      end
    end else if (ph[i] < n) begin
      ph[i] = ph[i] + 1;
    end else if (ph[i] == n) begin
      ph[i]      = n + 1;
      exp_res[i] = 8'(pend[i] & ((9'd1 << n) - 9'd1));
      exp_co[i]  = pend[i][n];
    end else begin
      ph[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      step(0, 4, bus4.start, 9'(bus4.num1) + 9'(bus4.num2));
      step(1, 8, bus8.start, 9'(bus8.num1) + 9'(bus8.num2));
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      ph[i]      = 0;
      exp_res[i] = 8'd0;
      exp_co[i]  = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("busy4", 9'(bus4.busy), 9'(ph[0] >= 1 && ph[0] <= 4));
    chk("done4", 9'(bus4.done), 9'(ph[0] == 5));
    chk("res4",  9'(bus4.Result), 9'(exp_res[0][3:0]));
    chk("co4",   9'(bus4.Carryout), 9'(exp_co[0]));
    chk("busy8", 9'(bus8.busy), 9'(ph[1] >= 1 && ph[1] <= 8));
    chk("done8", 9'(bus8.done), 9'(ph[1] == 9));
    chk("res8",  9'(bus8.Result), 9'(exp_res[1]));
    chk("co8",   9'(bus8.Carryout), 9'(exp_co[1]));
    if (bus4.done) done_cnt[0]++;
    if (bus8.done) done_cnt[1]++;
    if (bus4.busy) busy_cnt[0]++;
    if (bus8.busy) busy_cnt[1]++;
  end

  task automatic set_in(input int i, input logic st, input logic [7:0] a, input logic [7:0] b);
    if (i == 0) begin
      bus4.start = st; bus4.num1 = a[3:0]; bus4.num2 = b[3:0];
    end else begin
      bus8.start = st; bus8.num1 = a; bus8.num2 = b;
    end
  endtask

  function automatic logic get_done(input int i);
    return (i == 0) ? bus4.done : bus8.done;
  endfunction

  function automatic logic [8:0] get_sum(input int i);
    return (i == 0) ? {4'd0, bus4.Carryout, bus4.Result} : {bus8.Carryout, bus8.Result};
  endfunction

  // counts negedges until done is seen; optionally drops start after the first
  task automatic wait_done(input int i, input bit drop, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && drop) begin
        if (i == 0) bus4.start = 1'b0; else bus8.start = 1'b0;
      end
    end while (!get_done(i) && cyc < 40);
    if (!get_done(i)) begin
      checks++;
      fails++;
      $display("FAIL timeout%0d: no done after %0d cycles", i, cyc);
    end
  endtask

  task automatic op(input int i, input logic [7:0] a, input logic [7:0] b,
                    input logic [8:0] exp_carry_sum, input int lat, input string name);
    int cyc;
    @(negedge clk);
    busy_cnt[i] = 0;
    set_in(i, 1'b1, a, b);
    wait_done(i, 1'b1, cyc);
    chk({name, "_lat"}, 9'(cyc), 9'(lat));
    chk({name, "_sum"}, get_sum(i), exp_carry_sum);
  endtask

  initial begin
    int cyc;
    logic [7:0] ra, rb;
    set_in(0, 1'b0, 8'd0, 8'd0);
    set_in(1, 1'b0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 9'(bus4.busy), 9'd0);
    chk("rst_done", 9'(bus4.done), 9'd0);
    chk("rst_sum",  get_sum(0), 9'd0);
    rst_n = 1'b1;

    // 1010 + 0001
    op(0, 8'hA, 8'h1, 9'h0B, 5, "a_plus_1");
    @(negedge clk);
    chk("busy_cycles", 9'(busy_cnt[0]), 9'd4);
    op(0, 8'hF, 8'h1, 9'h10, 5, "f_plus_1");
    op(0, 8'hF, 8'hF, 9'h1E, 5, "f_plus_f");

    // start while busy is ignored
    @(negedge clk);
    done_cnt[0] = 0;
    set_in(0, 1'b1, 8'h3, 8'h4);
    @(negedge clk); set_in(0, 1'b0, 8'h3, 8'h4);
    @(negedge clk); set_in(0, 1'b1, 8'hF, 8'hF);
    @(negedge clk); set_in(0, 1'b0, 8'h5, 8'h9);
    wait_done(0, 1'b0, cyc);
    chk("ign_sum", get_sum(0), 9'h07);
    repeat (10) @(negedge clk);
    chk("ign_pulses", 9'(done_cnt[0]), 9'd1);

    // asynchronous reset in mid-addition
    @(negedge clk);
    set_in(0, 1'b1, 8'hA, 8'h6);
    @(negedge clk); set_in(0, 1'b0, 8'hA, 8'h6);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 9'(bus4.busy), 9'd0);
    chk("arst_done", 9'(bus4.done), 9'd0);
    chk("arst_sum",  get_sum(0), 9'd0);
    @(negedge clk); rst_n = 1'b1;
    op(0, 8'h5, 8'h5, 9'h0A, 5, "after_rst");

    // back-to-back with start held high
    @(negedge clk);
    set_in(0, 1'b1, 8'h1, 8'h1);
    wait_done(0, 1'b0, cyc);
    chk("b2b_lat1", 9'(cyc), 9'd5);
    chk("b2b_sum1", get_sum(0), 9'h02);
    set_in(0, 1'b1, 8'h7, 8'h1);
    wait_done(0, 1'b0, cyc);
    chk("b2b_gap", 9'(cyc), 9'd6);
    chk("b2b_sum2", get_sum(0), 9'h08);
    set_in(0, 1'b0, 8'h0, 8'h0);
    repeat (3) @(negedge clk);

    // N=8
    op(1, 8'd200, 8'd100, 9'h12C, 9, "n8_200_100");
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op(1, ra, rb, 9'(ra) + 9'(rb), 9, "n8_rand");
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
